voq_output_scheduler: RTL

Per-output read scheduler that drains the second-stage per-output VOQ bank of the shared-memory switch. It sits directly downstream of the switching module and has one lane per output port `i`. Each lane:
- watches that port's `N` per-source empty flags;
- picks a non-empty source round-robin and drives the switch's `rd_sel`/`rd_en`;
- captures the returned word into a 2-entry output buffer;
- presents the word to the egress side with a valid/ready handshake and counts delivered words.

---
 rtl/voq_output_scheduler.sv | 135 +++++++++++++
 1 files changed

// File: rtl/voq_output_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : voq_output_scheduler
// Description : Per-output read scheduler for the second-stage VOQ bank.
//               Each lane round-robins over its non-empty source queues,
//               issues credit-limited reads, buffers returned words in a
//               2-entry FIFO and hands them to egress via valid/ready.
// Revision    : 1.0 - initial release
// ============================================================================
module voq_output_scheduler #(
    parameter int PORT_NUB_TOTAL = 4,
    parameter int DATA_WIDTH     = 8,
    parameter int WIDTH_SEL      = $clog2(PORT_NUB_TOTAL)
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic [PORT_NUB_TOTAL*PORT_NUB_TOTAL-1:0] voq_empty,
    input  logic [PORT_NUB_TOTAL*DATA_WIDTH-1:0]     voq_rd_data,
    output logic [PORT_NUB_TOTAL*WIDTH_SEL-1:0]      rd_sel,
    output logic [PORT_NUB_TOTAL-1:0]                rd_en,
    output logic [PORT_NUB_TOTAL-1:0]                out_valid,
    input  logic [PORT_NUB_TOTAL-1:0]                out_ready,
    output logic [PORT_NUB_TOTAL*DATA_WIDTH-1:0]     out_data,
    output logic [PORT_NUB_TOTAL*WIDTH_SEL-1:0]      out_src,
    output logic [PORT_NUB_TOTAL*16-1:0]             pkt_cnt
);

    localparam logic [WIDTH_SEL-1:0] c_last_src = WIDTH_SEL'(PORT_NUB_TOTAL - 1);
    localparam logic [WIDTH_SEL:0]   c_n_ext    = (WIDTH_SEL + 1)'(PORT_NUB_TOTAL);

    for (genvar i = 0; i < PORT_NUB_TOTAL; i++) begin : g_lane
        logic [PORT_NUB_TOTAL-1:0] w_empty;
        logic [WIDTH_SEL-1:0]      r_ptr;
        logic [WIDTH_SEL-1:0]      r_src_d;
        logic                      r_inflight;
        logic [1:0]                r_occ;
        logic                      r_rd_idx;
        logic                      r_wr_idx;
        logic [WIDTH_SEL-1:0]      r_fifo_src  [2];
        logic [DATA_WIDTH-1:0]     r_fifo_data [2];
        logic [15:0]               r_cnt;
        logic [WIDTH_SEL-1:0]      w_grant;
        logic [WIDTH_SEL:0]        w_sum;
        logic                      w_found;
        logic                      w_pop;
        logic                      w_credit_ok;
        logic                      w_issue;

        assign w_empty = voq_empty[i*PORT_NUB_TOTAL +: PORT_NUB_TOTAL];
        assign w_pop   = (r_occ != 2'd0) & out_ready[i];

        // Round-robin search: first non-empty source starting at r_ptr
        always_comb begin
            w_found = 1'b0;
            w_grant = r_ptr;
            w_sum   = '0;
            for (int k = 0; k < PORT_NUB_TOTAL; k++) begin
                w_sum = {1'b0, r_ptr} + (WIDTH_SEL + 1)'(k);
                if (w_sum >= c_n_ext) begin
                    w_sum = w_sum - c_n_ext;
                end
                if (!w_found && !w_empty[w_sum[WIDTH_SEL-1:0]]) begin
                    w_found = 1'b1;
                    w_grant = w_sum[WIDTH_SEL-1:0];
                end
            end
        end

        // A pop this cycle frees a slot, so the credit test subtracts it.
        // occ + inflight never exceeds 2, so the 3-bit result cannot wrap.
        assign w_credit_ok = ({1'b0, r_occ} + {2'b00, r_inflight} - {2'b00, w_pop}) < 3'd2;
        assign w_issue     = w_found & w_credit_ok & ~rst;

        // Pointer advance and in-flight read tracking
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_ptr      <= '0;
                r_src_d    <= '0;
                r_inflight <= 1'b0;
            end else begin
                r_inflight <= w_issue;
                if (w_issue) begin
                    r_ptr   <= (w_grant == c_last_src) ? '0 : w_grant + WIDTH_SEL'(1);
                    r_src_d <= w_grant;
                end
            end
        end

        // Two-entry output FIFO: captures the word returned for last cycle's read
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_occ          <= 2'd0;
                r_rd_idx       <= 1'b0;
                r_wr_idx       <= 1'b0;
                r_fifo_src[0]  <= '0;
                r_fifo_src[1]  <= '0;
                r_fifo_data[0] <= '0;
                r_fifo_data[1] <= '0;
            end else begin
                if (r_inflight) begin
                    r_fifo_src[r_wr_idx]  <= r_src_d;
                    r_fifo_data[r_wr_idx] <= voq_rd_data[i*DATA_WIDTH +: DATA_WIDTH];
                    r_wr_idx              <= ~r_wr_idx;
                end
                if (w_pop) begin
                    r_rd_idx <= ~r_rd_idx;
                end
                case ({r_inflight, w_pop})
                    2'b10:   r_occ <= r_occ + 2'd1;
                    2'b01:   r_occ <= r_occ - 2'd1;
                    default: r_occ <= r_occ;
                endcase
            end
        end

        // Delivered-word counter, wraps modulo 2^16
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_cnt <= 16'd0;
            end else if (w_pop) begin
                r_cnt <= r_cnt + 16'd1;
            end
        end

        // rd_sel shows the grant while issuing, otherwise the last granted source
        assign rd_en[i]                               = w_issue;
        assign rd_sel[i*WIDTH_SEL +: WIDTH_SEL]       = w_issue ? w_grant : r_src_d;
        assign out_valid[i]                           = (r_occ != 2'd0);
        assign out_data[i*DATA_WIDTH +: DATA_WIDTH]   = r_fifo_data[r_rd_idx];
        assign out_src[i*WIDTH_SEL +: WIDTH_SEL]      = r_fifo_src[r_rd_idx];
        assign pkt_cnt[i*16 +: 16]                    = r_cnt;
    end

endmodule
`default_nettype wire
